data_plane_rx: RTL and testbench

//  Data-plane receiver; peer of the data-plane transmitter on the same 32-bit packet link.

---
 rtl/dp_pkg.sv | 18 +
 rtl/data_plane_rx_if.sv | 25 ++
 rtl/data_plane_rx_stack.sv | 55 +++++
 rtl/data_plane_rx.sv | 124 ++++++++++++
 tb/tb_data_plane_rx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared data-plane link definitions.
// The data-plane transmitter and receiver both use this package, so the packet
// layout and the frame length are defined only here.
//  PKT_LEN       payload packets per frame; the header packet is not counted
//  DP_IDLE_PKT   the value the link carries when nothing is being sent
//  dp_packet_t   link packet {dest, word}
//  dp_rx_state_t states of the receiver FSM
package dp_pkg;
  localparam int          PKT_LEN     = 4;
  localparam logic [31:0] DP_IDLE_PKT = 32'h0;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] word;
  } dp_packet_t;

  typedef enum logic [1:0] {RX_IDLE, RX_PAYLOAD, RX_DROP} dp_rx_state_t;
endpackage

// File: rtl/data_plane_rx_if.sv
// Link, GPP and status signals of the data-plane receiver.
//  master : the link/GPP side (drives node_id, data_rx_packet, gpp_rd_dp)
//  slave  : data_plane_rx (drives the stack view, src node and the pulses)
interface data_plane_rx_if;
  logic [15:0] node_id;
  logic [31:0] data_rx_packet;
  logic        gpp_rd_dp;
  logic [15:0] RAM_rx_data_out;
  logic [15:0] sp_rx_current;
  logic [15:0] data_rx_src_node;
  logic        data_rx_complete_flag;
  logic        data_rx_error_flag;

  modport master (
    output node_id, data_rx_packet, gpp_rd_dp,
    input  RAM_rx_data_out, sp_rx_current, data_rx_src_node,
           data_rx_complete_flag, data_rx_error_flag
  );

  modport slave (
    input  node_id, data_rx_packet, gpp_rd_dp,
    output RAM_rx_data_out, sp_rx_current, data_rx_src_node,
           data_rx_complete_flag, data_rx_error_flag
  );
endinterface

// File: rtl/data_plane_rx_stack.sv
// DEPTH x 16 LIFO holding received payload words for the GPP.
// Owns the stack pointer and all push/pop/rollback arithmetic.
//  clk, rst   clock, synchronous active-high reset (sp only; memory is not cleared)
//  push       write push_word this cycle
//  pop_req    GPP pop request
//  protect    words on top belonging to the frame in flight; a pop is honoured
//             only while at least one word lies beneath them
//  rollback   drop the protected words this cycle (frame abort)
//  room_ok    after this cycle's pop, at least NEED free slots remain
//  top_word   mem[sp-1], or 0 when empty
//  sp         stored word count
module data_plane_rx_stack
  import dp_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int NEED  = PKT_LEN,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [15:0]    push_word,
  input  logic           pop_req,
  input  logic [SPW-1:0] protect,
  input  logic           rollback,
  output logic           room_ok,
  output logic [15:0]    top_word,
  output logic [SPW-1:0] sp
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]    mem [DEPTH];
  logic           pop_ok;
  logic [SPW-1:0] sp_pop;
  logic [AW-1:0]  wr_addr, rd_addr;

  assign pop_ok  = pop_req && (sp > protect);
  assign sp_pop  = sp - SPW'(pop_ok);
  assign room_ok = (SPW'(DEPTH) - sp_pop) >= SPW'(NEED);

  // A push in the same cycle as a pop lands in the slot just vacated, so
  // the popped word is the old top and sp ends up unchanged.
  assign wr_addr  = AW'(sp_pop);
  assign rd_addr  = AW'(sp - SPW'(1));
  assign top_word = (sp == '0) ? 16'h0 : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) sp <= '0;
    else     sp <= sp_pop + SPW'(push) - (rollback ? protect : '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= push_word;
  end
endmodule

// File: rtl/data_plane_rx.sv
// Data-plane receiver: picks frames addressed to node_id off the 32-bit link,
// pushes their payload words onto the RX stack and reports completion/errors.
//  clk, rst  clock, synchronous active-high reset
//  bus       data_plane_rx_if.slave: node_id, data_rx_packet, gpp_rd_dp in;
//            RAM_rx_data_out, sp_rx_current, data_rx_src_node,
//            data_rx_complete_flag, data_rx_error_flag out
// A frame is a header {dest, src} followed by PKT_LEN packets {dest, word}.
// Frames that would not fit are dropped whole; a frame interrupted by any
// foreign packet is aborted and its words are rolled back off the stack.
module data_plane_rx
  import dp_pkg::*;
#(
  parameter int PKT_LEN = dp_pkg::PKT_LEN,
  parameter int DEPTH   = 64
) (
  input  logic             clk,
  input  logic             rst,
  data_plane_rx_if.slave   bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int CW  = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

  dp_packet_t     pkt;
  dp_rx_state_t   state, state_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic [15:0]    pend_src, src_q;
  logic           cmp_q, err_q;
  logic           ours, last_hit, room_ok;
  logic           push, rollback, latch_pend, take_src, set_complete, set_error;
  logic [SPW-1:0] sp, protect;

  assign pkt      = dp_packet_t'(bus.data_rx_packet);
  assign ours     = (bus.data_rx_packet != DP_IDLE_PKT) && (pkt.dest == bus.node_id);
  assign last_hit = (count == LAST);
  // In PAYLOAD, count is also the number of words this frame has pushed.
  assign protect  = (state == RX_PAYLOAD) ? SPW'(count) : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      count    <= '0;
      pend_src <= '0;
      src_q    <= '0;
      cmp_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      cmp_q <= set_complete;
      err_q <= set_error;
      if (latch_pend) pend_src <= pkt.word;
      if (take_src)   src_q    <= pend_src;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      RX_IDLE: begin
        if (ours) begin
          state_nxt = room_ok ? RX_PAYLOAD : RX_DROP;
          count_nxt = '0;
        end
      end
      RX_PAYLOAD: begin
        // A foreign packet ends the frame and is not reconsidered as a header.
        if (!ours)         state_nxt = RX_IDLE;
        else if (last_hit) state_nxt = RX_IDLE;
        else               count_nxt = count + CW'(1);
      end
      RX_DROP: begin
        if (!ours || last_hit) state_nxt = RX_IDLE;
        else                   count_nxt = count + CW'(1);
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    push         = 1'b0;
    rollback     = 1'b0;
    latch_pend   = 1'b0;
    take_src     = 1'b0;
    set_complete = 1'b0;
    set_error    = 1'b0;
    case (state)
      RX_IDLE: begin
        latch_pend = ours && room_ok;
        set_error  = ours && !room_ok;
      end
      RX_PAYLOAD: begin
        push         = ours;
        take_src     = ours && last_hit;
        set_complete = ours && last_hit;
        rollback     = !ours;
        set_error    = !ours;
      end
      default: ;
    endcase
  end

  data_plane_rx_stack #(.DEPTH(DEPTH), .NEED(PKT_LEN)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (pkt.word),
    .pop_req   (bus.gpp_rd_dp),
    .protect   (protect),
    .rollback  (rollback),
    .room_ok   (room_ok),
    .top_word  (bus.RAM_rx_data_out),
    .sp        (sp)
  );

  assign bus.sp_rx_current         = 16'(sp);
  assign bus.data_rx_src_node      = src_q;
  assign bus.data_rx_complete_flag = cmp_q;
  assign bus.data_rx_error_flag    = err_q;
endmodule

// File: tb/tb_data_plane_rx.sv
module tb_data_plane_rx;
  localparam int          PKT_LEN = 4;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] NODE    = 16'h0005;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  data_plane_rx_if bus();

  data_plane_rx #(.PKT_LEN(PKT_LEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One link cycle: drive, clock, sample just after the edge, tally pulses.
  task automatic cyc(input logic [31:0] p, input logic pop);
    bus.data_rx_packet = p;
    bus.gpp_rd_dp      = pop;
    @(posedge clk);
    #1;
    if (bus.data_rx_complete_flag === 1'b1) n_cmp++;
    if (bus.data_rx_error_flag === 1'b1)    n_err++;
  endtask

  task automatic send(input logic [15:0] dest, input logic [15:0] src,
                      input logic [15:0] base, input int npay, input logic pop);
    cyc({dest, src}, pop);
    for (int i = 1; i <= npay; i++) cyc({dest, base + 16'(i)}, pop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(32'h0, 1'b0);
    cyc(32'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (bus.sp_rx_current !== 16'h0) begin nmis++; $display("FAIL reset_sp: got %0h want 0", bus.sp_rx_current); end
    nvec++; if (bus.RAM_rx_data_out !== 16'h0) begin nmis++; $display("FAIL reset_top: got %0h want 0", bus.RAM_rx_data_out); end
    nvec++; if (bus.data_rx_src_node !== 16'h0) begin nmis++; $display("FAIL reset_src: got %0h want 0", bus.data_rx_src_node); end
    nvec++; if (bus.data_rx_complete_flag !== 1'b0 || bus.data_rx_error_flag !== 1'b0) begin
      nmis++; $display("FAIL reset_flags: got c=%b e=%b want 0 0", bus.data_rx_complete_flag, bus.data_rx_error_flag); end
  endtask

  task automatic test_frame();
    int c0, e0;
    c0 = n_cmp; e0 = n_err;
    send(NODE, 16'h0009, 16'h00A0, PKT_LEN - 1, 1'b0);
    nvec++; if (bus.data_rx_complete_flag !== 1'b0) begin nmis++; $display("FAIL frame_early_complete: got 1 want 0"); end
    cyc({NODE, 16'h00A4}, 1'b0);
    nvec++; if (bus.data_rx_complete_flag !== 1'b1) begin nmis++; $display("FAIL frame_complete_timing: got 0 want 1"); end
    cyc(32'h0, 1'b0);
    nvec++; if (bus.data_rx_complete_flag !== 1'b0) begin nmis++; $display("FAIL frame_complete_width: got 1 want 0"); end
    nvec++; if (bus.sp_rx_current !== 16'd4) begin nmis++; $display("FAIL frame_sp: got %0d want 4", bus.sp_rx_current); end
    nvec++; if (bus.data_rx_src_node !== 16'h0009) begin nmis++; $display("FAIL frame_src: got %0h want 9", bus.data_rx_src_node); end
    nvec++; if (n_cmp - c0 !== 1 || n_err - e0 !== 0) begin nmis++; $display("FAIL frame_pulses: got c=%0d e=%0d want 1 0", n_cmp - c0, n_err - e0); end
    for (int i = 4; i >= 1; i--) begin
      nvec++; if (bus.RAM_rx_data_out !== 16'h00A0 + 16'(i)) begin
        nmis++; $display("FAIL frame_pop: got %0h want %0h", bus.RAM_rx_data_out, 16'h00A0 + 16'(i)); end
      cyc(32'h0, 1'b1);
    end
    nvec++; if (bus.sp_rx_current !== 16'd0 || bus.RAM_rx_data_out !== 16'h0) begin
      nmis++; $display("FAIL frame_empty: got sp=%0d top=%0h want 0 0", bus.sp_rx_current, bus.RAM_rx_data_out); end
    cyc(32'h0, 1'b1);
    nvec++; if (bus.sp_rx_current !== 16'd0) begin nmis++; $display("FAIL pop_empty: got %0d want 0", bus.sp_rx_current); end
  endtask

  task automatic test_other_dest();
    int c0, e0;
    c0 = n_cmp; e0 = n_err;
    send(16'h0007, 16'h0033, 16'h00B0, PKT_LEN, 1'b0);
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd0) begin nmis++; $display("FAIL other_sp: got %0d want 0", bus.sp_rx_current); end
    nvec++; if (bus.data_rx_src_node !== 16'h0009) begin nmis++; $display("FAIL other_src: got %0h want 9", bus.data_rx_src_node); end
    nvec++; if (n_cmp - c0 !== 0 || n_err - e0 !== 0) begin nmis++; $display("FAIL other_pulses: got c=%0d e=%0d want 0 0", n_cmp - c0, n_err - e0); end
  endtask

  task automatic test_abort();
    int c0, e0;
    c0 = n_cmp; e0 = n_err;
    send(NODE, 16'h0011, 16'h00C0, 2, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd2) begin nmis++; $display("FAIL abort_partial_sp: got %0d want 2", bus.sp_rx_current); end
    cyc(32'h0, 1'b0);
    nvec++; if (bus.data_rx_error_flag !== 1'b1 || bus.sp_rx_current !== 16'd0) begin
      nmis++; $display("FAIL abort_rollback: got e=%b sp=%0d want 1 0", bus.data_rx_error_flag, bus.sp_rx_current); end
    cyc(32'h0, 1'b0);
    send(NODE, 16'h0012, 16'h00D0, PKT_LEN, 1'b0);
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd4 || bus.RAM_rx_data_out !== 16'h00D4) begin
      nmis++; $display("FAIL abort_next_frame: got sp=%0d top=%0h want 4 d4", bus.sp_rx_current, bus.RAM_rx_data_out); end
    nvec++; if (bus.data_rx_src_node !== 16'h0012) begin nmis++; $display("FAIL abort_next_src: got %0h want 12", bus.data_rx_src_node); end
    nvec++; if (n_cmp - c0 !== 1 || n_err - e0 !== 1) begin nmis++; $display("FAIL abort_pulses: got c=%0d e=%0d want 1 1", n_cmp - c0, n_err - e0); end
  endtask

  task automatic test_drop();
    int c0, e0;
    logic [15:0] w;
    do_reset();
    c0 = n_cmp; e0 = n_err;
    // Back-to-back frames; the second exactly fills the stack.
    send(NODE, 16'h0001, 16'h0010, PKT_LEN, 1'b0);
    send(NODE, 16'h0002, 16'h0020, PKT_LEN, 1'b0);
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd8 || n_cmp - c0 !== 2) begin
      nmis++; $display("FAIL b2b_fill: got sp=%0d c=%0d want 8 2", bus.sp_rx_current, n_cmp - c0); end
    for (int i = 0; i < 3; i++) cyc(32'h0, 1'b1);
    c0 = n_cmp; e0 = n_err;
    send(NODE, 16'h0003, 16'h0030, PKT_LEN, 1'b0);
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd5 || bus.RAM_rx_data_out !== 16'h0021) begin
      nmis++; $display("FAIL drop_stack: got sp=%0d top=%0h want 5 21", bus.sp_rx_current, bus.RAM_rx_data_out); end
    nvec++; if (n_cmp - c0 !== 0 || n_err - e0 !== 1) begin nmis++; $display("FAIL drop_pulses: got c=%0d e=%0d want 0 1", n_cmp - c0, n_err - e0); end
    nvec++; if (bus.data_rx_src_node !== 16'h0002) begin nmis++; $display("FAIL drop_src: got %0h want 2", bus.data_rx_src_node); end
    // Admission counts room after the header cycle's pop.
    c0 = n_cmp; e0 = n_err;
    cyc({NODE, 16'h0004}, 1'b1);
    for (int i = 1; i <= PKT_LEN; i++) cyc({NODE, 16'h0040 + 16'(i)}, 1'b0);
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd8 || n_cmp - c0 !== 1 || n_err - e0 !== 0) begin
      nmis++; $display("FAIL admit_after_pop: got sp=%0d c=%0d e=%0d want 8 1 0", bus.sp_rx_current, n_cmp - c0, n_err - e0); end
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? 16'h0044 - 16'(i) : 16'h0014 - 16'(i - 4);
      nvec++; if (bus.RAM_rx_data_out !== w) begin nmis++; $display("FAIL admit_contents: got %0h want %0h", bus.RAM_rx_data_out, w); end
      cyc(32'h0, 1'b1);
    end
  endtask

  task automatic test_pop_during_frame();
    do_reset();
    send(NODE, 16'h0001, 16'h00B0, PKT_LEN, 1'b0);
    cyc(32'h0, 1'b1);
    cyc(32'h0, 1'b1);
    nvec++; if (bus.RAM_rx_data_out !== 16'h00B2) begin nmis++; $display("FAIL popf_old2: got %0h want b2", bus.RAM_rx_data_out); end
    cyc({NODE, 16'h0066}, 1'b1);
    nvec++; if (bus.RAM_rx_data_out !== 16'h00B1) begin nmis++; $display("FAIL popf_old1: got %0h want b1", bus.RAM_rx_data_out); end
    for (int i = 1; i <= PKT_LEN; i++) begin
      cyc({NODE, 16'h00C0 + 16'(i)}, 1'b1);
      nvec++; if (bus.RAM_rx_data_out !== 16'h00C0 + 16'(i)) begin
        nmis++; $display("FAIL popf_guard: got %0h want %0h", bus.RAM_rx_data_out, 16'h00C0 + 16'(i)); end
    end
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd4 || bus.data_rx_src_node !== 16'h0066) begin
      nmis++; $display("FAIL popf_final: got sp=%0d src=%0h want 4 66", bus.sp_rx_current, bus.data_rx_src_node); end
  endtask

  task automatic test_reset_mid_frame();
    int c0, e0;
    do_reset();
    c0 = n_cmp; e0 = n_err;
    send(NODE, 16'h0007, 16'h00E0, 2, 1'b0);
    rst = 1'b1;
    cyc(32'h0, 1'b0);
    rst = 1'b0;
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd0 || n_cmp - c0 !== 0 || n_err - e0 !== 0) begin
      nmis++; $display("FAIL rstmid_clear: got sp=%0d c=%0d e=%0d want 0 0 0", bus.sp_rx_current, n_cmp - c0, n_err - e0); end
    send(NODE, 16'h0008, 16'h00F0, PKT_LEN, 1'b0);
    cyc(32'h0, 1'b0);
    nvec++; if (bus.sp_rx_current !== 16'd4 || bus.RAM_rx_data_out !== 16'h00F4 || bus.data_rx_src_node !== 16'h0008) begin
      nmis++; $display("FAIL rstmid_next: got sp=%0d top=%0h src=%0h want 4 f4 8", bus.sp_rx_current, bus.RAM_rx_data_out, bus.data_rx_src_node); end
    nvec++; if (n_cmp - c0 !== 1 || n_err - e0 !== 0) begin nmis++; $display("FAIL rstmid_pulses: got c=%0d e=%0d want 1 0", n_cmp - c0, n_err - e0); end
  endtask

  // Transaction-level model: a queue of stored words; a frame appends its
  // words only if PKT_LEN slots are free, otherwise (or if cut short) it
  // leaves the queue alone and costs exactly one error pulse.
  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] exp_src, s, base, dest, exp_top;
    int kind, n, c0, e0, exp_c, exp_e;
    do_reset();
    exp_src = 16'h0;
    for (int t = 0; t < 80; t++) begin
      kind  = int'($urandom_range(0, 4));
      s     = 16'($urandom);
      base  = 16'($urandom);
      c0    = n_cmp; e0 = n_err;
      exp_c = 0; exp_e = 0;
      case (kind)
        0: begin
          send(NODE, s, base, PKT_LEN, 1'b0);
          if (DEPTH - q.size() >= PKT_LEN) begin
            for (int i = 1; i <= PKT_LEN; i++) q.push_back(base + 16'(i));
            exp_src = s;
            exp_c   = 1;
          end else exp_e = 1;
        end
        1: begin
          dest = 16'($urandom_range(6, 300));
          send(dest, s, base, PKT_LEN, 1'b0);
        end
        2: begin
          n = int'($urandom_range(0, PKT_LEN - 1));
          send(NODE, s, base, n, 1'b0);
          exp_e = 1;
        end
        3: begin
          n = int'($urandom_range(1, 3));
          for (int i = 0; i < n; i++) begin
            exp_top = (q.size() > 0) ? q[$] : 16'h0;
            nvec++; if (bus.RAM_rx_data_out !== exp_top) begin
              nmis++; $display("FAIL rand_pop t=%0d: got %0h want %0h", t, bus.RAM_rx_data_out, exp_top); end
            cyc(32'h0, 1'b1);
            if (q.size() > 0) void'(q.pop_back());
          end
        end
        default: cyc(32'h0, 1'b0);
      endcase
      cyc(32'h0, 1'b0);
      exp_top = (q.size() > 0) ? q[$] : 16'h0;
      nvec++; if (bus.sp_rx_current !== 16'(q.size()) || bus.RAM_rx_data_out !== exp_top) begin
        nmis++; $display("FAIL rand_stack t=%0d: got sp=%0d top=%0h want %0d %0h", t, bus.sp_rx_current, bus.RAM_rx_data_out, q.size(), exp_top); end
      nvec++; if (bus.data_rx_src_node !== exp_src) begin
        nmis++; $display("FAIL rand_src t=%0d: got %0h want %0h", t, bus.data_rx_src_node, exp_src); end
      nvec++; if (n_cmp - c0 !== exp_c || n_err - e0 !== exp_e) begin
        nmis++; $display("FAIL rand_pulses t=%0d: got c=%0d e=%0d want %0d %0d", t, n_cmp - c0, n_err - e0, exp_c, exp_e); end
    end
  endtask

  initial begin
    bus.node_id        = NODE;
    bus.data_rx_packet = 32'h0;
    bus.gpp_rd_dp      = 1'b0;
    test_reset();
    test_frame();
    test_other_dest();
    test_abort();
    test_drop();
    test_pop_during_frame();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
